uart_fifo_controller: RTL and testbench

//  Host-side front end for the UART driver. It queues outgoing bytes in a TX FIFO and sequences them

---
 rtl/uart_fifo_controller_pkg.sv | 18 +
 rtl/uart_fifo_controller_sync_fifo.sv | 73 +++++++
 rtl/uart_fifo_controller.sv | 161 ++++++++++++++++
 tb/tb_uart_fifo_controller.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_fifo_controller_pkg.sv
// Shared definitions for the UART FIFO controller.
// Contents: 2-bit TX FSM state encodings, the drop-counter width, and the occupancy-width formula
// (LW = $clog2(depth+1)) used by the top and by the FIFO sub-module.
package uart_fifo_controller_pkg;

    localparam logic [1:0] TX_IDLE      = 2'd0;
    localparam logic [1:0] TX_START     = 2'd1;
    localparam logic [1:0] TX_WAIT_LOW  = 2'd2;
    localparam logic [1:0] TX_WAIT_HIGH = 2'd3;

    localparam int unsigned DROP_CNT_W = 16;

    // Occupancy needs one more code than the depth so that "full" is representable.
    function automatic int level_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/uart_fifo_controller_sync_fifo.sv
// Synchronous FIFO with registered full/empty/level flags.
// Ports: clk, rst_n (sync active-low), push/din (write), pop/dout (read; dout shows the head entry),
//        full, empty, level (occupancy).
// A push while full is accepted only if a pop happens in the same cycle; a pop while empty is
// ignored.
module uart_fifo_controller_sync_fifo
    import uart_fifo_controller_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    localparam int LW = level_width(DEPTH),
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [LW-1:0]    level
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [LW-1:0]    wr_cnt_q, wr_cnt_d;
    logic [LW-1:0]    rd_cnt_q, rd_cnt_d;
    logic [LW-1:0]    level_q, level_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;
    logic             push_ok, pop_ok;

    assign pop_ok  = pop && !empty_q;
    assign push_ok = push && (!full_q || pop_ok);

    // Counters carry one extra bit; the low AW bits are the wrapping memory pointers.
    always_comb begin
        wr_cnt_d = wr_cnt_q;
        rd_cnt_d = rd_cnt_q;
        if (push_ok) wr_cnt_d = wr_cnt_q + LW'(1);
        if (pop_ok)  rd_cnt_d = rd_cnt_q + LW'(1);
        level_d = wr_cnt_d - rd_cnt_d;
        full_d  = (level_d == LW'(DEPTH));
        empty_d = (level_d == '0);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_cnt_q <= '0;
            rd_cnt_q <= '0;
            level_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_cnt_q <= wr_cnt_d;
            rd_cnt_q <= rd_cnt_d;
            level_q  <= level_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_cnt_q[AW-1:0]] <= din;
    end

    // Read-before-write: a pop+push on a full FIFO returns the old head.
    assign dout  = mem_q[rd_cnt_q[AW-1:0]];
    assign full  = full_q;
    assign empty = empty_q;
    assign level = level_q;

endmodule

// File: rtl/uart_fifo_controller.sv
// Host-side front end for the UART driver: TX FIFO sequenced into the driver's
// tx_start/tx_ready handshake, and RX FIFO capturing each rx_new_data pulse.
// Ports: sys_clk, rst_n (sync active-low); host TX side wr_en/wr_data/tx_full/tx_level;
//        host RX side rd_en/rd_data/rd_valid/rx_empty/rx_level/rx_overrun/clr_overrun;
//        driver side drv_tx_start/drv_tx_data/drv_tx_ready/drv_rx_new_data/drv_rx_data.
// Build option: define UART_FIFO_OVERRUN_CNT_EN to add rx_drop_count[15:0], a saturating count
//        of dropped RX bytes cleared by clr_overrun.
module uart_fifo_controller
    import uart_fifo_controller_pkg::*;
#(
    parameter int NUM_DATA_BITS = 8,
    parameter int FIFO_DEPTH    = 16,
    localparam int LW = level_width(FIFO_DEPTH)
) (
    input  logic                     sys_clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [NUM_DATA_BITS-1:0] wr_data,
    output logic                     tx_full,
    output logic [LW-1:0]            tx_level,
    input  logic                     rd_en,
    output logic [NUM_DATA_BITS-1:0] rd_data,
    output logic                     rd_valid,
    output logic                     rx_empty,
    output logic [LW-1:0]            rx_level,
    output logic                     rx_overrun,
    input  logic                     clr_overrun,
`ifdef UART_FIFO_OVERRUN_CNT_EN
    output logic [DROP_CNT_W-1:0]    rx_drop_count,
`endif
    output logic                     drv_tx_start,
    output logic [NUM_DATA_BITS-1:0] drv_tx_data,
    input  logic                     drv_tx_ready,
    input  logic                     drv_rx_new_data,
    input  logic [NUM_DATA_BITS-1:0] drv_rx_data
);

    logic [1:0]               state_q, state_d;
    logic                     tx_start_q, tx_start_d;
    logic [NUM_DATA_BITS-1:0] tx_data_q, tx_data_d;
    logic [NUM_DATA_BITS-1:0] rd_data_q, rd_data_d;
    logic                     rd_valid_q, rd_valid_d;
    logic                     overrun_q, overrun_d;

    logic                     tx_push, tx_pop, tx_empty;
    logic [NUM_DATA_BITS-1:0] tx_dout;
    logic                     rx_pop, rx_full, rx_drop;
    logic [NUM_DATA_BITS-1:0] rx_dout;

    // A write while full is dropped even if the FSM pops in the same cycle.
    assign tx_push = wr_en && !tx_full;

    uart_fifo_controller_sync_fifo #(
        .WIDTH (NUM_DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_tx_fifo (
        .clk   (sys_clk),
        .rst_n (rst_n),
        .push  (tx_push),
        .pop   (tx_pop),
        .din   (wr_data),
        .dout  (tx_dout),
        .full  (tx_full),
        .empty (tx_empty),
        .level (tx_level)
    );

    assign rx_pop  = rd_en && !rx_empty;
    assign rx_drop = drv_rx_new_data && rx_full && !rx_pop;

    uart_fifo_controller_sync_fifo #(
        .WIDTH (NUM_DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_rx_fifo (
        .clk   (sys_clk),
        .rst_n (rst_n),
        .push  (drv_rx_new_data),
        .pop   (rx_pop),
        .din   (drv_rx_data),
        .dout  (rx_dout),
        .full  (rx_full),
        .empty (rx_empty),
        .level (rx_level)
    );

    // TX sequencing: launch only with the driver idle, then wait for it to go busy and
    // come back, so a start pulse can never be missed or doubled.
    always_comb begin
        state_d    = state_q;
        tx_start_d = 1'b0;
        tx_data_d  = tx_data_q;
        tx_pop     = 1'b0;
        case (state_q)
            TX_IDLE: begin
                if (!tx_empty && drv_tx_ready) begin
                    tx_pop     = 1'b1;
                    tx_data_d  = tx_dout;
                    tx_start_d = 1'b1;
                    state_d    = TX_START;
                end
            end
            TX_START:     state_d = TX_WAIT_LOW;
            TX_WAIT_LOW:  if (!drv_tx_ready) state_d = TX_WAIT_HIGH;
            TX_WAIT_HIGH: if (drv_tx_ready) state_d = TX_IDLE;
            default:      state_d = TX_IDLE;
        endcase
    end

    always_comb begin
        rd_data_d  = rx_pop ? rx_dout : rd_data_q;
        rd_valid_d = rx_pop;
        // Set has priority over clear.
        overrun_d  = rx_drop ? 1'b1 : (clr_overrun ? 1'b0 : overrun_q);
    end

    always_ff @(posedge sys_clk) begin
        if (!rst_n) begin
            state_q    <= TX_IDLE;
            tx_start_q <= 1'b0;
            tx_data_q  <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            tx_start_q <= tx_start_d;
            tx_data_q  <= tx_data_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            overrun_q  <= overrun_d;
        end
    end

`ifdef UART_FIFO_OVERRUN_CNT_EN
    logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (clr_overrun) begin
            // A drop coinciding with the clear is still counted.
            drop_cnt_d = rx_drop ? DROP_CNT_W'(1) : '0;
        end else if (rx_drop && (drop_cnt_q != '1)) begin
            drop_cnt_d = drop_cnt_q + DROP_CNT_W'(1);
        end
    end

    always_ff @(posedge sys_clk) begin
        if (!rst_n) drop_cnt_q <= '0;
        else        drop_cnt_q <= drop_cnt_d;
    end

    assign rx_drop_count = drop_cnt_q;
`endif

    assign drv_tx_start = tx_start_q;
    assign drv_tx_data  = tx_data_q;
    assign rd_data      = rd_data_q;
    assign rd_valid     = rd_valid_q;
    assign rx_overrun   = overrun_q;

endmodule

// File: tb/tb_uart_fifo_controller.sv
// Directed self-checking bench for uart_fifo_controller; the bench itself plays the UART driver
// with TX looped back to RX.
module tb_uart_fifo_controller;

    logic       sys_clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       wr_en = 1'b0;
    logic [7:0] wr_data = '0;
    logic       tx_full;
    logic [4:0] tx_level;
    logic       rd_en = 1'b0;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       rx_empty;
    logic [4:0] rx_level;
    logic       rx_overrun;
    logic       clr_overrun = 1'b0;
`ifdef UART_FIFO_OVERRUN_CNT_EN
    logic [15:0] rx_drop_count;
`endif
    logic       drv_tx_start;
    logic [7:0] drv_tx_data;
    logic       drv_tx_ready = 1'b1;
    logic       drv_rx_new_data = 1'b0;
    logic [7:0] drv_rx_data = '0;

    int checks = 0;
    int failures = 0;

    always #5 sys_clk = ~sys_clk;

    uart_fifo_controller #(
        .NUM_DATA_BITS (8),
        .FIFO_DEPTH    (16)
    ) dut (
        .sys_clk         (sys_clk),
        .rst_n           (rst_n),
        .wr_en           (wr_en),
        .wr_data         (wr_data),
        .tx_full         (tx_full),
        .tx_level        (tx_level),
        .rd_en           (rd_en),
        .rd_data         (rd_data),
        .rd_valid        (rd_valid),
        .rx_empty        (rx_empty),
        .rx_level        (rx_level),
        .rx_overrun      (rx_overrun),
        .clr_overrun     (clr_overrun),
`ifdef UART_FIFO_OVERRUN_CNT_EN
        .rx_drop_count   (rx_drop_count),
`endif
        .drv_tx_start    (drv_tx_start),
        .drv_tx_data     (drv_tx_data),
        .drv_tx_ready    (drv_tx_ready),
        .drv_rx_new_data (drv_rx_new_data),
        .drv_rx_data     (drv_rx_data)
    );

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Driver model: wait for a start pulse, go busy, then deliver the frame back on RX.
    task automatic send_frame(input string tag, output logic [7:0] b);
        int n;
        n = 0;
        while (drv_tx_start !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        check({tag, "_start_seen"}, 32'(drv_tx_start), 32'd1);
        b = drv_tx_data;
        tick();
        drv_tx_ready = 1'b0;
        tick();
        tick();
        tick();
        check({tag, "_data_held"}, 32'(drv_tx_data), 32'(b));
        drv_tx_ready    = 1'b1;
        drv_rx_new_data = 1'b1;
        drv_rx_data     = b;
        tick();
        drv_rx_new_data = 1'b0;
    endtask

    initial begin
        logic [7:0] got;
        int         max_lvl;
        bit         started;

        // Reset state
        tick();
        tick();
        check("rst_tx_start", 32'(drv_tx_start), 32'd0);
        check("rst_tx_data", 32'(drv_tx_data), 32'd0);
        check("rst_rd_data", 32'(rd_data), 32'd0);
        check("rst_rd_valid", 32'(rd_valid), 32'd0);
        check("rst_overrun", 32'(rx_overrun), 32'd0);
        check("rst_tx_full", 32'(tx_full), 32'd0);
        check("rst_rx_empty", 32'(rx_empty), 32'd1);
        check("rst_tx_level", 32'(tx_level), 32'd0);
        check("rst_rx_level", 32'(rx_level), 32'd0);
        rst_n = 1'b1;
        tick();

        // Two bytes, sent in order and looped back
        wr_en = 1'b1; wr_data = 8'hA5;
        tick();
        check("t1_level_a", 32'(tx_level), 32'd1);
        wr_data = 8'h3C;
        tick();
        wr_en = 1'b0;
        // push of 0x3C and pop of 0xA5 in the same cycle
        check("t1_level_b", 32'(tx_level), 32'd1);
        send_frame("t1_f0", got);
        check("t1_frame0", 32'(got), 32'hA5);
        send_frame("t1_f1", got);
        check("t1_frame1", 32'(got), 32'h3C);
        check("t1_rx_level", 32'(rx_level), 32'd2);
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        check("t1_rd_valid0", 32'(rd_valid), 32'd1);
        check("t1_rd_data0", 32'(rd_data), 32'hA5);
        tick();
        check("t1_rd_valid_pulse", 32'(rd_valid), 32'd0);
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        check("t1_rd_data1", 32'(rd_data), 32'h3C);
        check("t1_overrun", 32'(rx_overrun), 32'd0);

        // 17 writes while the driver is busy
        drv_tx_ready = 1'b0;
        max_lvl = 0;
        for (int i = 0; i < 17; i++) begin
            wr_en = 1'b1;
            wr_data = 8'h10 + 8'(i);
            tick();
            if (int'(tx_level) > max_lvl) max_lvl = int'(tx_level);
        end
        wr_en = 1'b0;
        tick();
        check("t2_tx_full", 32'(tx_full), 32'd1);
        check("t2_tx_level", 32'(tx_level), 32'd16);
        check("t2_max_level", 32'(max_lvl), 32'd16);

        // Launch the head byte, then reset during TX_WAIT_HIGH
        drv_tx_ready = 1'b1;
        tick();
        check("t6_head_start", 32'(drv_tx_start), 32'd1);
        check("t6_head_data", 32'(drv_tx_data), 32'h10);
        tick();
        drv_tx_ready = 1'b0;
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("t6_tx_level", 32'(tx_level), 32'd0);
        check("t6_rx_level", 32'(rx_level), 32'd0);
        check("t6_tx_start", 32'(drv_tx_start), 32'd0);
        check("t6_tx_full", 32'(tx_full), 32'd0);
        wr_en = 1'b1; wr_data = 8'h5A;
        tick();
        wr_en = 1'b0;
        started = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (drv_tx_start === 1'b1) started = 1'b1;
        end
        check("t6_no_launch_busy", 32'(started), 32'd0);
        drv_tx_ready = 1'b1;
        send_frame("t6_f", got);
        check("t6_frame", 32'(got), 32'h5A);
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        check("t6_rd_data", 32'(rd_data), 32'h5A);

        // 17 received frames, no reads
        for (int i = 0; i < 17; i++) begin
            drv_rx_new_data = 1'b1;
            drv_rx_data = 8'h80 + 8'(i);
            tick();
        end
        drv_rx_new_data = 1'b0;
        check("t3_rx_level", 32'(rx_level), 32'd16);
        check("t3_overrun", 32'(rx_overrun), 32'd1);
`ifdef UART_FIFO_OVERRUN_CNT_EN
        check("t3_drop_count", 32'(rx_drop_count), 32'd1);
`endif
        clr_overrun = 1'b1;
        tick();
        clr_overrun = 1'b0;
        check("t5_clr_overrun", 32'(rx_overrun), 32'd0);
`ifdef UART_FIFO_OVERRUN_CNT_EN
        check("t5_clr_count", 32'(rx_drop_count), 32'd0);
`endif

        // Full RX with rd_en in the cycle of a new byte
        drv_rx_new_data = 1'b1; drv_rx_data = 8'hEE; rd_en = 1'b1;
        tick();
        drv_rx_new_data = 1'b0;
        check("t4_rd_data", 32'(rd_data), 32'h80);
        check("t4_rx_level", 32'(rx_level), 32'd16);
        check("t4_overrun", 32'(rx_overrun), 32'd0);
        // rd_en stays high: drain the rest in order; 0x90 was dropped
        for (int i = 0; i < 16; i++) begin
            tick();
            check("t4_drain", 32'(rd_data), (i < 15) ? 32'h81 + 32'(i) : 32'hEE);
        end

        // rd_en while empty
        tick();
        rd_en = 1'b0;
        check("t5_empty_valid", 32'(rd_valid), 32'd0);
        check("t5_rx_empty", 32'(rx_empty), 32'd1);

        // Clear coinciding with a new overrun: set wins
        for (int i = 0; i < 16; i++) begin
            drv_rx_new_data = 1'b1;
            drv_rx_data = 8'(i);
            tick();
        end
        clr_overrun = 1'b1;
        tick();
        drv_rx_new_data = 1'b0;
        clr_overrun = 1'b0;
        check("t5_set_wins", 32'(rx_overrun), 32'd1);
        clr_overrun = 1'b1;
        tick();
        clr_overrun = 1'b0;
        check("t5_clr_again", 32'(rx_overrun), 32'd0);
`ifdef UART_FIFO_OVERRUN_CNT_EN
        check("t5_count_again", 32'(rx_drop_count), 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
